alu_pipe_nbit: RTL and testbench
================================

# alu_pipe_nbit

Parametrised, two-stage pipelined N-bit ALU with valid/ready handshakes on both sides, status flags, an accumulator chaining mode and a completed-operation counter. It keeps the 3-bit ALOP encodings of the existing combinational N-bit ALU and defines the two previously unused codes. It sits between an operand source and a result consumer, and either side may stall.

## Interface
- W, 32: operand/result width (≥4).
- CNT_W, 16: width of the completed-operation counter.
- SW, $clog2(W): derived shift-amount width; not overridden.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- c_in  in  1  carry-in; used by ALOP 110 only.
- alop  in  3  operation select.
- acc_sel  in  1  when 1, the accumulator replaces `a` for this bundle.
- acc_clr  in  1  synchronous accumulator clear.
- result  out  W  registered result.
- flags  out  4  {carry, overflow, negative, zero}, registered with result.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- op_count  out  CNT_W  number of completed output handshakes; wraps.

## Operation
- S1 register: holds {a or acc marker, b, c_in, alop, acc_sel}, plus s1_valid. Loads on input handshake (in_valid && in_ready).
- S2 register: holds {result, flags}, plus out_valid. Loads on advance = s1_valid && (!out_valid || out_ready).
- Compute happens on S1 contents during the advance cycle. Effective A = acc when S1.acc_sel = 1, else S1.a.
- ALOP (A, B):
  - 000: A
  - 001: ~A
  - 010: A << B[SW-1:0] (logical)
  - 011: A & B
  - 100: A | B
  - 101: A − B
  - 110: A + B + c_in
  - 111: A ^ B
- Arithmetic is modulo 2^W.
- carry:
  - 110: bit W of the (W+1)-bit sum.
  - 101: borrow, i.e. 1 iff A < B unsigned.
  - all other ops: 0.
- overflow:
  - 110: signed overflow of A+B+c_in.
  - 101: signed overflow of A−B.
  - all other ops: 0.
- negative = result[W-1]; zero = (result == 0).
- Accumulator:
  - Each advance writes acc with the computed result.
  - acc_clr = 1 sets acc to 0 on the next edge and has priority over a simultaneous advance write.
  - A bundle already in S1 with acc_sel reads acc at its advance, so chained ops see the immediately preceding op's result. No hazard exists.
- op_count increments on each output handshake (out_valid && out_ready) and wraps at 2^CNT_W.

## Timing
- Reset (asynchronous, while rst_n = 0):
  - s1_valid = 0, out_valid = 0, result = 0, flags = 0, acc = 0, op_count = 0.
  - in_ready = 1 after reset is released.
  - In-flight bundles are discarded.
- in_ready = !s1_valid || advance. This is combinational from out_ready, with no combinational path from in_valid.
- Latency:
  - Bundle accepted at edge T → out_valid = 1 after edge T+1 when unstalled.
  - Throughput is one op per cycle when out_ready is held at 1.
- Stall (out_valid && !out_ready):
  - result, flags and out_valid hold.
  - S1 holds.
  - in_ready = !s1_valid.
  - At most 2 bundles are in flight.
- Simultaneous output handshake and advance in the same cycle: S2 is overwritten with the new result, out_valid stays 1, and no bubble is inserted.
- S2 drains with no advance pending: out_valid falls after the handshake edge.
- in_valid may be held high with changing data. Only handshake-edge values are captured.
- acc_clr is independent of the handshakes and takes effect one edge later.

## Test plan
- W=8, out_ready=1, back-to-back bundles (a=0x7F, b=0x01, alop=110, c_in=0), then (a=0x05, b=0x05, alop=101):
  - results 0x80 with flags carry=0, ovf=1, neg=1, zero=0, then 0x00 with zero=1, carry=0.
  - Each output appears 2 cycles after its input; one result per cycle.
- W=8, all ALOPs on a=0xA5, b=0x03, including 010 → 0x28 and 111 → 0xA6. Every result and flag is checked against a reference model.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1. in_ready must drop after 2 accepted bundles, and result must stay stable. Releasing out_ready must drain in order with no loss or duplication; op_count increases by exactly the number of handshakes.
- Accumulator chain:
  - acc_clr pulse, then 4 bundles alop=110, acc_sel=1, b=3 back-to-back → results 3, 6, 9, 12.
  - acc_clr asserted in the same cycle as an advance → next acc_sel op sees acc = 0.
- Reset mid-operation: assert rst_n=0 with both stages full and out_ready=0 → out_valid, result, flags, op_count and acc are 0 immediately. After release, in_ready=1 and the first new bundle is processed normally.
- CNT_W=4: 17 completed handshakes → op_count = 1 (wraps).

Source files
------------

// File: rtl/alu_pipe_nbit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pipe_nbit - two-stage valid/ready pipelined N-bit ALU with status flags,
//                 accumulator chaining and a completed-operation counter
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_pipe_nbit #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             c_in,
  input  logic [2:0]       alop,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic [W-1:0]     result,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  localparam int SW = $clog2(W);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_ADC  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic         s1_cin;
  logic [2:0]   s1_alop;
  logic         s1_acc_sel;
  logic [W-1:0] acc;

  logic         advance;
  logic         in_hs;
  logic         out_hs;
  logic [W-1:0] eff_a;
  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic [W-1:0] alu_res;
  logic         alu_carry;
  logic         alu_ovf;

  assign out_hs   = out_valid && out_ready;
  assign advance  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || advance;
  assign in_hs    = in_valid && in_ready;

  // acc is read at advance time, so a chained op always sees its predecessor's result
  assign eff_a    = s1_acc_sel ? acc : s1_a;
  assign sum_ext  = {1'b0, eff_a} + {1'b0, s1_b} + {{W{1'b0}}, s1_cin};
  assign diff_ext = {1'b0, eff_a} - {1'b0, s1_b};

  always_comb begin
    alu_res   = eff_a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (s1_alop)
      OP_PASS: alu_res = eff_a;
      OP_NOT:  alu_res = ~eff_a;
      OP_SHL:  alu_res = eff_a << s1_b[SW-1:0];
      OP_AND:  alu_res = eff_a & s1_b;
      OP_OR:   alu_res = eff_a | s1_b;
      OP_SUB: begin
        alu_res   = diff_ext[W-1:0];
        alu_carry = diff_ext[W];
        alu_ovf   = (eff_a[W-1] != s1_b[W-1]) && (diff_ext[W-1] != eff_a[W-1]);
      end
      OP_ADC: begin
        alu_res   = sum_ext[W-1:0];
        alu_carry = sum_ext[W];
        alu_ovf   = (eff_a[W-1] == s1_b[W-1]) && (sum_ext[W-1] != eff_a[W-1]);
      end
      OP_XOR:  alu_res = eff_a ^ s1_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_cin     <= 1'b0;
      s1_alop    <= 3'b000;
      s1_acc_sel <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      flags      <= 4'b0000;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      if (in_hs) begin
        s1_a       <= a;
        s1_b       <= b;
        s1_cin     <= c_in;
        s1_alop    <= alop;
        s1_acc_sel <= acc_sel;
      end
      if (in_hs)
        s1_valid <= 1'b1;
      else if (advance)
        s1_valid <= 1'b0;

      if (advance) begin
        result    <= alu_res;
        flags     <= {alu_carry, alu_ovf, alu_res[W-1], (alu_res == '0)};
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      // a clear wins over the write-back of a simultaneous advance
      if (acc_clr)
        acc <= '0;
      else if (advance)
        acc <= alu_res;

      if (out_hs)
        op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_nbit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_pipe_nbit - self-checking bench: directed scenarios plus random traffic
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_pipe_nbit;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             c_in = 1'b0;
  logic [2:0]       alop = 3'b000;
  logic             acc_sel = 1'b0;
  logic             acc_clr = 1'b0;
  logic [W-1:0]     result;
  logic [3:0]       flags;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] op_count;

  alu_pipe_nbit #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .alop(alop), .acc_sel(acc_sel), .acc_clr(acc_clr),
    .result(result), .flags(flags), .out_valid(out_valid), .out_ready(out_ready),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic
  function automatic void ref_alu(input longint ra, input longint rb, input longint rc,
                                  input int op, output logic [W-1:0] r, output logic [3:0] f);
    longint m, sa, sb, s, full;
    bit c, v;
    m = longint'(1) << W;
    sa = (ra >= m / 2) ? ra - m : ra;
    sb = (rb >= m / 2) ? rb - m : rb;
    c = 0; v = 0; full = 0;
    case (op)
      0: full = ra;
      1: full = m - 1 - ra;
      2: full = ra << (rb % W);
      3: full = ra & rb;
      4: full = ra | rb;
      5: begin full = ra - rb; c = (ra < rb); s = sa - sb; v = (s < -(m / 2)) || (s >= m / 2); end
      6: begin full = ra + rb + rc; c = (full >= m); s = sa + sb + rc; v = (s < -(m / 2)) || (s >= m / 2); end
      default: full = ra ^ rb;
    endcase
    full = ((full % m) + m) % m;
    r = W'(full);
    f = {c, v, r[W-1], (full == 0)};
  endfunction

  // Transaction-level model: one pending slot feeding one output slot
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [2:0]   op;
    logic         sel;
  } bundle_t;

  bundle_t      pend_q[$];
  bit           m_ov = 0;
  logic [W-1:0] m_res = '0;
  logic [3:0]   m_flags = '0;
  logic [W-1:0] m_acc = '0;
  int           m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit leave, move, take;
    bundle_t bd;
    logic [W-1:0] r;
    logic [3:0] f;
    if (!rst_n) begin
      pend_q.delete();
      m_ov = 0; m_res = '0; m_flags = '0; m_acc = '0; m_cnt = 0;
    end else begin
      leave = m_ov && out_ready;
      move  = (pend_q.size() != 0) && (!m_ov || out_ready);
      take  = in_valid && ((pend_q.size() == 0) || move);
      r = '0;
      if (leave) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (move) begin
        bd = pend_q.pop_front();
        ref_alu(longint'(bd.sel ? m_acc : bd.a), longint'(bd.b), longint'(bd.cin), int'(bd.op), r, f);
        m_res = r; m_flags = f; m_ov = 1;
      end else if (leave) begin
        m_ov = 0;
      end
      if (acc_clr) m_acc = '0;
      else if (move) m_acc = r;
      if (take) pend_q.push_back({a, b, c_in, alop, acc_sel});
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'((pend_q.size() == 0) || !m_ov || out_ready));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("op_count", 32'(op_count), 32'(m_cnt));
      if (m_ov) begin
        chk("result", 32'(result), 32'(m_res));
        chk("flags", 32'(flags), 32'(m_flags));
      end
    end
  end

  logic [W+3:0] got[$];
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) got.push_back({result, flags});

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                      input logic [2:0] top, input logic tsel);
    int n;
    bit ok;
    n = 0; ok = 0;
    a = ta; b = tbv; c_in = tc; alop = top; acc_sel = tsel; in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!ok) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    do begin
      @(negedge clk); n++;
    end while ((out_valid || pend_q.size() != 0) && n < 50);
    if (n >= 50) chk("drain_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  logic [W+3:0] alu_exp [8] = '{12'hA52, 12'h5A0, 12'h280, 12'h010,
                                12'hA72, 12'hA22, 12'hA82, 12'hA62};

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int acc_n;
    bit ir_last, held_set;
    logic [W-1:0] held;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_flags", 32'(flags), 32'(0));
    chk("rst_op_count", 32'(op_count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Back-to-back add overflow then subtract-to-zero, with latency checks
    out_ready = 1'b1;
    a = 8'h7F; b = 8'h01; c_in = 1'b0; alop = 3'b110; acc_sel = 1'b0; in_valid = 1'b1;
    @(negedge clk); chk("lat_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    a = 8'h05; b = 8'h05; alop = 3'b101;
    @(negedge clk); chk("lat_t0_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_out_valid", 32'(out_valid), 32'(1));
    chk("add_result", 32'(result), 32'(8'h80));
    chk("add_flags", 32'(flags), 32'(4'b0110));
    @(posedge clk); #1;
    @(negedge clk);
    chk("sub_out_valid", 32'(out_valid), 32'(1));
    chk("sub_result", 32'(result), 32'(8'h00));
    chk("sub_flags", 32'(flags), 32'(4'b0001));
    @(posedge clk); #1;
    @(negedge clk); chk("drained_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;

    // All operations on A5/03
    got.delete();
    for (int op = 0; op < 8; op++) send(8'hA5, 8'h03, 1'b0, 3'(op), 1'b0);
    drain();
    chk("allop_count", 32'(got.size()), 32'(8));
    for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("allop_%0d", i), 32'(got[i]), 32'(alu_exp[i]));
    chk("allop_op_count", 32'(op_count), 32'(10));

    // Backpressure with in_valid held and data changing every cycle
    got.delete();
    out_ready = 1'b0; acc_n = 0; held_set = 0; held = '0; ir_last = 1;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); alop = 3'($urandom);
      acc_sel = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      ir_last = in_ready;
      if (in_ready) acc_n++;
      if (out_valid) begin
        if (held_set) chk("stall_result_hold", 32'(result), 32'(held));
        held = result; held_set = 1;
      end
      @(posedge clk); #1;
    end
    chk("stall_accepted", 32'(acc_n), 32'(2));
    chk("stall_in_ready", 32'(ir_last), 32'(0));
    drain();
    chk("stall_drain_count", 32'(got.size()), 32'(2));
    chk("stall_op_count", 32'(op_count), 32'(12));

    // Accumulator chain after a clear
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) send(W'($urandom), 8'h03, 1'b0, 3'b110, 1'b1);
    drain();
    chk("chain_count", 32'(got.size()), 32'(4));
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("chain_%0d", i), 32'(got[i][W+3:4]), 32'(3 * (i + 1)));

    // Clear coinciding with an advance wins over the write-back
    got.delete();
    send(8'h10, 8'h01, 1'b0, 3'b000, 1'b0);
    acc_clr = 1'b1;
    send(W'($urandom), 8'h05, 1'b0, 3'b110, 1'b1);
    acc_clr = 1'b0;
    drain();
    chk("clr_adv_count", 32'(got.size()), 32'(2));
    if (got.size() == 2) begin
      chk("clr_adv_first", 32'(got[0]), 32'(12'h100));
      chk("clr_adv_second", 32'(got[1]), 32'(12'h050));
    end

    // Reset with both stages full and the consumer stalled
    out_ready = 1'b0;
    send(8'h33, 8'h44, 1'b0, 3'b100, 1'b0);
    send(8'h01, 8'h02, 1'b0, 3'b110, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_result", 32'(result), 32'(0));
    chk("midrst_flags", 32'(flags), 32'(0));
    chk("midrst_op_count", 32'(op_count), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Acc cleared by reset; then 17 handshakes wrap the 4-bit counter to 1
    got.delete();
    out_ready = 1'b1;
    send(8'h5A, 8'h00, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 16; i++) send(W'($urandom), W'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
    drain();
    chk("wrap_count", 32'(got.size()), 32'(17));
    if (got.size() > 0) chk("postrst_acc_zero", 32'(got[0]), 32'(12'h001));
    chk("wrap_op_count", 32'(op_count), 32'(1));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      c_in      = 1'($urandom);
      alop      = 3'($urandom);
      acc_sel   = 1'($urandom);
      acc_clr   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    acc_clr = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
